m_port_ultra_hull_result_streamer: RTL and testbench

//  Drains the parallel result of the quickhull processor (convexPoints bus, convexSetSize).
//  On a hull_done pulse it snapshots the bus, then emits hull points one per transfer on a

---
 rtl/m_port_ultra_hull_result_streamer.sv | 123 ++++++++++++
 tb/tb_m_port_ultra_hull_result_streamer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_port_ultra_hull_result_streamer.sv
// Quickhull result streamer. On hull_done it snapshots the parallel hull bus and
// emits the points on a valid/ready stream, index 0 first. Because the bus is
// snapshotted, the processor can start its next frame while this one drains.
module m_port_ultra_hull_result_streamer #(
   parameter int unsigned POINT_W    = 16,
   parameter int unsigned MAX_POINTS = 256,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                          CLK100MHZ,
   input  logic                          CPU_RESETN,
   input  logic                          hull_done,
   input  logic [POINT_W*MAX_POINTS-1:0] convexPoints,
   input  logic [CNT_W-1:0]              convexSetSize,
   input  logic                          err_clear,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [POINT_W-1:0]            out_point,
   output logic [CNT_W-1:0]              out_index,
   output logic                          out_last,
   output logic                          busy,
   output logic                          frame_done,
   output logic                          overrun_err
);

   localparam int unsigned BUS_W = POINT_W * MAX_POINTS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   state_t             state;
   logic [BUS_W-1:0]   shadow;
   logic [CNT_W-1:0]   size;
   logic [CNT_W-1:0]   idx;
   logic [CNT_W-1:0]   nxt_idx;
   logic               capture;

   // A capture is only taken while idle; hull_done anywhere else is an overrun.
   assign capture = hull_done && (state == IDLE);
   assign nxt_idx = idx + CNT_W'(1);
   assign out_index = idx;

   // Snapshot of the processor bus; holds its value until the next capture.
   always_ff @(posedge CLK100MHZ) begin
      if (capture) begin
         shadow <= convexPoints;
      end
   end

   // Frame sequencer: IDLE -> STREAM -> FLUSH -> IDLE, with registered stream outputs.
   // out_point is preloaded from the next slot so it is valid the cycle idx moves.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state      <= IDLE;
         size       <= '0;
         idx        <= '0;
         out_valid  <= 1'b0;
         out_point  <= '0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (hull_done) begin
                  size      <= convexSetSize;
                  idx       <= '0;
                  out_point <= convexPoints[POINT_W-1:0];
                  busy      <= 1'b1;
                  if (convexSetSize != '0) begin
                     state     <= STREAM;
                     out_valid <= 1'b1;
                     out_last  <= (convexSetSize == CNT_W'(1));
                  end else begin
                     // Empty hull: skip straight to the completion pulse.
                     state      <= FLUSH;
                     frame_done <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (out_ready) begin
                  if (out_last) begin
                     state      <= FLUSH;
                     out_valid  <= 1'b0;
                     out_last   <= 1'b0;
                     frame_done <= 1'b1;
                  end else begin
                     idx       <= nxt_idx;
                     out_point <= shadow[POINT_W*32'(nxt_idx) +: POINT_W];
                     out_last  <= (nxt_idx == (size - CNT_W'(1)));
                  end
               end
            end
            FLUSH: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overrun flag; a new overrun wins over a simultaneous clear.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         overrun_err <= 1'b0;
      end else if (hull_done && (state != IDLE)) begin
         overrun_err <= 1'b1;
      end else if (err_clear) begin
         overrun_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_m_port_ultra_hull_result_streamer.sv
// Directed bench for the hull result streamer.
module tb_m_port_ultra_hull_result_streamer;

   localparam int unsigned POINT_W    = 16;
   localparam int unsigned MAX_POINTS = 256;
   localparam int unsigned CNT_W      = 8;

   logic                          clk;
   logic                          rst_n;
   logic                          hull_done;
   logic [POINT_W*MAX_POINTS-1:0] bus;
   logic [CNT_W-1:0]              set_size;
   logic                          err_clear;
   logic                          out_valid;
   logic                          out_ready;
   logic [POINT_W-1:0]            out_point;
   logic [CNT_W-1:0]              out_index;
   logic                          out_last;
   logic                          busy;
   logic                          frame_done;
   logic                          overrun_err;

   int checks = 0;
   int errors = 0;

   m_port_ultra_hull_result_streamer #(
      .POINT_W(POINT_W), .MAX_POINTS(MAX_POINTS), .CNT_W(CNT_W)
   ) dut (
      .CLK100MHZ    (clk),
      .CPU_RESETN   (rst_n),
      .hull_done    (hull_done),
      .convexPoints (bus),
      .convexSetSize(set_size),
      .err_clear    (err_clear),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_point    (out_point),
      .out_index    (out_index),
      .out_last     (out_last),
      .busy         (busy),
      .frame_done   (frame_done),
      .overrun_err  (overrun_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse hull_done for one cycle; returns in cycle N+1.
   task automatic fire(input logic [CNT_W-1:0] sz);
      set_size  = sz;
      hull_done = 1'b1;
      tick();
      hull_done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; hull_done = 1'b0; err_clear = 1'b0; out_ready = 1'b0;
      set_size = '0; bus = '0;
      #3;
      checks++;
      if ({out_valid, out_last, busy, frame_done, overrun_err} !== 5'b0 ||
          out_point !== 16'h0 || out_index !== 8'h0) begin
         errors++;
         $display("FAIL reset_outputs got v%b l%b b%b fd%b oe%b pt%h ix%0d want all 0",
                  out_valid, out_last, busy, frame_done, overrun_err, out_point, out_index);
      end
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [15:0] exp_pt [3];
      exp_pt[0] = 16'h0102; exp_pt[1] = 16'h0304; exp_pt[2] = 16'h0506;
      bus = '0;
      for (int i = 0; i < 3; i++) bus[16*i +: 16] = exp_pt[i];
      out_ready = 1'b1;
      fire(8'd3);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_point !== exp_pt[i] || out_index !== 8'(i) ||
             out_last !== (i == 2) || busy !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_point%0d got v%b pt%h ix%0d l%b b%b fd%b want v1 pt%h ix%0d l%b b1 fd0",
                     i, out_valid, out_point, out_index, out_last, busy, frame_done,
                     exp_pt[i], i, (i == 2));
         end
         tick();
      end
      checks++;
      if (out_valid !== 1'b0 || frame_done !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_frame_done got v%b fd%b b%b want v0 fd1 b1",
                  out_valid, frame_done, busy);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || frame_done !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle got b%b fd%b v%b want 0 0 0", busy, frame_done, out_valid);
      end
   endtask

   task automatic test_ready_toggle();
      logic        pat [6];
      int          xfers, fds;
      logic        stalled;
      logic [15:0] prev_pt;
      logic [7:0]  prev_ix;
      logic        prev_l;
      pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1;
      xfers = 0; fds = 0; stalled = 1'b0;
      prev_pt = '0; prev_ix = '0; prev_l = 1'b0;
      out_ready = 1'b0;
      fire(8'd3);
      for (int c = 0; c < 12; c++) begin
         out_ready = (c < 6) ? pat[c] : 1'b1;
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_point !== prev_pt || out_index !== prev_ix ||
                out_last !== prev_l) begin
               errors++;
               $display("FAIL toggle_stable c%0d got v%b pt%h ix%0d l%b want v1 pt%h ix%0d l%b",
                        c, out_valid, out_point, out_index, out_last, prev_pt, prev_ix, prev_l);
            end
         end
         if (frame_done === 1'b1) fds++;
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (out_point !== bus[16*xfers +: 16] || out_index !== 8'(xfers) ||
                out_last !== (xfers == 2)) begin
               errors++;
               $display("FAIL toggle_xfer%0d got pt%h ix%0d l%b want pt%h ix%0d l%b",
                        xfers, out_point, out_index, out_last, bus[16*xfers +: 16],
                        xfers, (xfers == 2));
            end
            xfers++;
         end
         stalled = (out_valid === 1'b1) && !out_ready;
         prev_pt = out_point; prev_ix = out_index; prev_l = out_last;
         tick();
      end
      checks++;
      if (xfers != 3 || fds != 1) begin
         errors++;
         $display("FAIL toggle_count got xfers=%0d frame_done=%0d want 3 1", xfers, fds);
      end
   endtask

   task automatic test_empty();
      out_ready = 1'b1;
      fire(8'd0);
      checks++;
      if (out_valid !== 1'b0 || frame_done !== 1'b1 || busy !== 1'b1 || overrun_err !== 1'b0) begin
         errors++;
         $display("FAIL empty_n1 got v%b fd%b b%b oe%b want v0 fd1 b1 oe0",
                  out_valid, frame_done, busy, overrun_err);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 || overrun_err !== 1'b0) begin
         errors++;
         $display("FAIL empty_n2 got v%b fd%b b%b oe%b want 0 0 0 0",
                  out_valid, frame_done, busy, overrun_err);
      end
   endtask

   task automatic test_overrun();
      bus = '0;
      for (int i = 0; i < 5; i++) bus[16*i +: 16] = 16'h1000 + 16'(i);
      out_ready = 1'b1;
      fire(8'd5);
      bus = {(POINT_W*MAX_POINTS/16){16'hFFFF}};
      set_size = 8'd2;
      for (int i = 0; i < 5; i++) begin
         // overrun on cycle 0, overrun+clear together on cycle 1
         hull_done = (i < 2);
         err_clear = (i == 1);
         checks++;
         if (out_valid !== 1'b1 || out_point !== 16'h1000 + 16'(i) || out_index !== 8'(i) ||
             out_last !== (i == 4)) begin
            errors++;
            $display("FAIL overrun_point%0d got v%b pt%h ix%0d l%b want v1 pt%h ix%0d l%b",
                     i, out_valid, out_point, out_index, out_last, 16'h1000 + 16'(i), i, (i == 4));
         end
         tick();
      end
      hull_done = 1'b0; err_clear = 1'b0;
      checks++;
      if (frame_done !== 1'b1 || overrun_err !== 1'b1) begin
         errors++;
         $display("FAIL overrun_done got fd%b oe%b want fd1 oe1", frame_done, overrun_err);
      end
      tick(); tick();
      checks++;
      if (overrun_err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL overrun_sticky got oe%b b%b v%b want oe1 b0 v0", overrun_err, busy, out_valid);
      end
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      checks++;
      if (overrun_err !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clear got oe%b want 0", overrun_err);
      end
   endtask

   task automatic test_reset_mid_stream();
      bus = '0;
      for (int i = 0; i < 5; i++) bus[16*i +: 16] = 16'h2200 + 16'(i);
      out_ready = 1'b1;
      fire(8'd5);
      tick(); tick();
      checks++;
      if (out_index !== 8'd2 || out_point !== 16'h2202) begin
         errors++;
         $display("FAIL midrst_pre got ix%0d pt%h want ix2 pt2202", out_index, out_point);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || out_index !== 8'd0) begin
         errors++;
         $display("FAIL midrst_async got v%b b%b fd%b ix%0d want 0 0 0 0",
                  out_valid, busy, frame_done, out_index);
      end
      #2 rst_n = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_after got v%b fd%b b%b want 0 0 0", out_valid, frame_done, busy);
      end
      bus[15:0] = 16'hAB01; bus[31:16] = 16'hAB02;
      fire(8'd2);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_index !== 8'(i) || out_point !== 16'hAB01 + 16'(i) ||
             out_last !== (i == 1)) begin
            errors++;
            $display("FAIL midrst_new%0d got v%b ix%0d pt%h l%b want v1 ix%0d pt%h l%b",
                     i, out_valid, out_index, out_point, out_last, i, 16'hAB01 + 16'(i), (i == 1));
         end
         tick();
      end
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("FAIL midrst_done got fd%b want 1", frame_done);
      end
      tick();
   endtask

   task automatic test_full_random();
      logic [15:0] exp_pt [256];
      int xfers, fds, lasts;
      bit finished;
      for (int i = 0; i < 256; i++) begin
         exp_pt[i] = 16'($urandom);
         bus[16*i +: 16] = exp_pt[i];
      end
      xfers = 0; fds = 0; lasts = 0; finished = 0;
      out_ready = 1'b0;
      fire(8'd255);
      for (int c = 0; c < 3000 && !finished; c++) begin
         out_ready = 1'($urandom_range(0, 1));
         if (frame_done === 1'b1) begin
            fds++;
            finished = 1;
         end
         if (out_valid === 1'b1 && out_last === 1'b1 && out_ready) lasts++;
         if (out_valid === 1'b1 && out_ready) begin
            if (out_point !== exp_pt[xfers] || out_index !== 8'(xfers) ||
                out_last !== (xfers == 254)) begin
               checks++;
               errors++;
               $display("FAIL random_xfer%0d got pt%h ix%0d l%b want pt%h ix%0d l%b",
                        xfers, out_point, out_index, out_last, exp_pt[xfers], xfers, (xfers == 254));
            end
            xfers++;
         end
         tick();
      end
      checks++;
      if (!finished || xfers != 255 || lasts != 1) begin
         errors++;
         $display("FAIL random_frame got done=%0d xfers=%0d lasts=%0d want 1 255 1",
                  finished, xfers, lasts);
      end
      tick(); tick();
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL random_idle got fd%b b%b v%b want 0 0 0", frame_done, busy, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ready_toggle();
      test_empty();
      test_overrun();
      test_reset_mid_stream();
      test_full_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
